// File: rtl/ultrasonic_pkg.sv
// Shared definitions for the ultrasonic scan scheduler: FSM encoding,
// tick width and default timing.
package ultrasonic_pkg;

  localparam int TICK_W = 24;

  localparam int DEF_NUM_SENSORS    = 4;
  localparam int DEF_TRIG_CYCLES    = 500;        // 10 us at 50 MHz
  localparam int DEF_TIMEOUT_CYCLES = 1_250_000;
  localparam int DEF_GAP_CYCLES     = 500_000;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_TRIG      = 3'd1;
  localparam state_t ST_WAIT_RISE = 3'd2;
  localparam state_t ST_MEASURE   = 3'd3;
  localparam state_t ST_GAP       = 3'd4;

  localparam logic [TICK_W-1:0] TICK_MAX = '1;

  function automatic logic [TICK_W-1:0] sat_inc(input logic [TICK_W-1:0] v);
    return (v == TICK_MAX) ? v : v + TICK_W'(1);
  endfunction

endpackage

// File: rtl/echo_sync.sv
// Two-flop synchronizer bank for the asynchronous echo lines.
module echo_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // NOTE: non-blocking assignments so each stage samples its pre-edge input.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/ultrasonic_scan_scheduler.sv
// Round-robin trigger/echo scheduler for a bank of ultrasonic rangers; one
// shared timer paces trigger width, echo timeout and the inter-ping gap.
module ultrasonic_scan_scheduler
  import ultrasonic_pkg::*;
#(
  parameter int NUM_SENSORS    = DEF_NUM_SENSORS,
  parameter int TRIG_CYCLES    = DEF_TRIG_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES
) (
  input  logic                   clk,
  input  logic                   reset_l,
  input  logic                   enable,
  input  logic [NUM_SENSORS-1:0] sensor_mask,
  input  logic [NUM_SENSORS-1:0] echo,
  output logic [NUM_SENSORS-1:0] trigger,
  output logic                   result_valid,
  output logic [2:0]             result_id,
  output logic [TICK_W-1:0]      result_ticks,
  output logic                   result_timeout,
  output logic                   busy
);

  localparam int MAX_A   = (TRIG_CYCLES > GAP_CYCLES) ? TRIG_CYCLES : GAP_CYCLES;
  localparam int MAX_CYC = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int TIMER_W = $clog2(MAX_CYC + 1);
  localparam int SEL_W   = $clog2(NUM_SENSORS);

  localparam logic [TIMER_W-1:0] TRIG_LAST    = TIMER_W'(TRIG_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] GAP_LAST     = TIMER_W'(GAP_CYCLES - 1);

  state_t               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [TICK_W-1:0]    ticks_q, ticks_d;
  logic [NUM_SENSORS-1:0] echo_s, echo_prev_q;

  logic                 res_valid_q;
  logic [SEL_W-1:0]     res_id_q;
  logic [TICK_W-1:0]    res_ticks_q;
  logic                 res_to_q;

  logic [SEL_W-1:0]     next_sel, cand;
  logic                 found;
  logic                 start, done, done_to;
  logic                 echo_sel, echo_rise;

  echo_sync #(.WIDTH(NUM_SENSORS)) u_echo_sync (
    .clk     (clk),
    .reset_l (reset_l),
    .async_i (echo),
    .sync_o  (echo_s)
  );

  // Only the selected sensor's line is ever looked at; a line already high
  // on entry to WAIT_RISE has no low-to-high edge and so is never a rise.
  assign echo_sel  = echo_s[sel_q];
  assign echo_rise = echo_s[sel_q] && !echo_prev_q[sel_q];
  assign start     = enable && (|sensor_mask);

  // First set mask bit strictly after the last served index, wrapping.
  always_comb begin
    next_sel = sel_q;
    cand     = '0;
    found    = 1'b0;
    for (int k = 1; k <= NUM_SENSORS; k++) begin
      cand = SEL_W'((int'(sel_q) + k) % NUM_SENSORS);
      if (!found && sensor_mask[cand]) begin
        next_sel = cand;
        found    = 1'b1;
      end
    end
  end

  // NOTE: every _d gets a default before the case so no path infers a latch.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q + TIMER_W'(1);
    sel_d   = sel_q;
    ticks_d = ticks_q;
    done    = 1'b0;
    done_to = 1'b0;
    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (start) begin
          state_d = ST_TRIG;
          sel_d   = next_sel;
        end
      end
      ST_TRIG: begin
        if (timer_q == TRIG_LAST) begin
          state_d = ST_WAIT_RISE;
          timer_d = '0;
          ticks_d = '0;
        end
      end
      ST_WAIT_RISE: begin
        if (echo_rise) begin
          state_d = ST_MEASURE;
          ticks_d = TICK_W'(1);
        end
        if (timer_q == TIMEOUT_LAST) begin
          done    = 1'b1;
          done_to = 1'b1;
        end
      end
      ST_MEASURE: begin
        if (!echo_sel) begin
          done = 1'b1;
        end else begin
          ticks_d = sat_inc(ticks_q);
          if (timer_q == TIMEOUT_LAST) begin
            done    = 1'b1;
            done_to = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (timer_q == GAP_LAST) begin
          timer_d = '0;
          if (start) begin
            state_d = ST_TRIG;
            sel_d   = next_sel;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase
    if (done) begin
      state_d = ST_GAP;
      timer_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      sel_q       <= SEL_W'(NUM_SENSORS - 1);
      ticks_q     <= '0;
      echo_prev_q <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_ticks_q <= '0;
      res_to_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      sel_q       <= sel_d;
      ticks_q     <= ticks_d;
      echo_prev_q <= echo_s;
      res_valid_q <= done;
      if (done) begin
        res_id_q    <= sel_q;
        res_ticks_q <= ticks_d;
        res_to_q    <= done_to;
      end
    end
  end

  always_comb begin
    trigger = '0;
    if (state_q == ST_TRIG) trigger[sel_q] = 1'b1;
  end

  assign busy           = (state_q != ST_IDLE);
  assign result_valid   = res_valid_q;
  assign result_id      = 3'(res_id_q);
  assign result_ticks   = res_ticks_q;
  assign result_timeout = res_to_q;

endmodule

// File: doc/ultrasonic_scan_scheduler.md
ULTRASONIC_SCAN_SCHEDULER -- requirements
Module: ultrasonic_scan_scheduler

Interface
REQ-001 Parameter NUM_SENSORS, 4, number of ultrasonic sensors sharing the scan schedule (2..8).
REQ-002 Parameter TRIG_CYCLES, 500, trigger pulse width in clk cycles (10 us at 50 MHz).
REQ-003 Parameter TIMEOUT_CYCLES, 1_250_000, max cycles from trigger end to echo fall before timeout.
REQ-004 Parameter GAP_CYCLES, 500_000, quiet cycles after each ping before the next trigger (crosstalk guard).
REQ-005 clk  input  1  system clock; all state on rising edge.
REQ-006 reset_l  input  1  reset, asynchronous, active-low.
REQ-007 enable  input  1  level; 1 = scanning runs, 0 = finish current ping then idle.
REQ-008 sensor_mask  input  NUM_SENSORS  1 = sensor participates in the scan.
REQ-009 echo  input  NUM_SENSORS  asynchronous echo lines, one per sensor.
REQ-010 trigger  output  NUM_SENSORS  trigger lines, at most one bit high at any time.
REQ-011 result_valid  output  1  single-cycle pulse, one completed measurement.
REQ-012 result_id  output  3  sensor index of the result.
REQ-013 result_ticks  output  24  echo-high width in clk cycles, saturating at 24'hFFFFFF.
REQ-014 result_timeout  output  1  qualifies result_valid; 1 = no complete echo within TIMEOUT_CYCLES.
REQ-015 busy  output  1  1 in every state except IDLE.

Function
REQ-016 Each echo bit SHALL pass through a 2-flop synchronizer; all echo timing refers to the synchronized value.
REQ-017 FSM states SHALL be IDLE, TRIG, WAIT_RISE, MEASURE, GAP.
REQ-018 IDLE -> TRIG when enable=1 and sensor_mask != 0; the selected sensor is the next set mask bit after the last served index, wrapping modulo NUM_SENSORS (round-robin); first selection after reset starts at index 0.
REQ-019 TRIG SHALL drive trigger[sel]=1 for exactly TRIG_CYCLES cycles, then -> WAIT_RISE with the timeout counter cleared.
REQ-020 WAIT_RISE -> MEASURE on synchronized echo[sel] rising; the width counter starts at 1 on the first cycle echo is seen high.
REQ-021 MEASURE increments result_ticks by 1 per high cycle, saturating; -> GAP on echo[sel] low, pulsing result_valid=1 with result_timeout=0 in that same transition cycle.
REQ-022 The timeout counter SHALL run through WAIT_RISE and MEASURE; on reaching TIMEOUT_CYCLES -> GAP with result_valid=1, result_timeout=1, result_ticks=count so far (0 if no rise).
REQ-023 If echo[sel] is already high on entry to WAIT_RISE (stale echo), no rise is detected; the ping ends by timeout.
REQ-024 GAP SHALL count GAP_CYCLES with all triggers low, then -> TRIG (next sensor) if enable=1 and mask != 0, else -> IDLE.
REQ-025 enable or sensor_mask changes mid-ping SHALL NOT abort the ping; they are sampled only at IDLE and GAP exit.
REQ-026 A mask bit cleared mid-ping SHALL still produce that ping's result; a single-bit mask SHALL reselect the same sensor every ping.
REQ-027 result_id, result_ticks, result_timeout SHALL hold their values until the next result_valid.
REQ-028 Echo activity on non-selected sensors SHALL be ignored.

Reset
REQ-029 reset_l low SHALL asynchronously force state IDLE, trigger=0, result_valid=0, result_id=0, result_ticks=0, result_timeout=0, busy=0, synchronizers=0, round-robin pointer so index 0 is chosen next.
REQ-030 Reset asserted mid-ping SHALL drop trigger immediately and emit no result.

Structure
REQ-031 Shared package ultrasonic_pkg SHALL hold the state enum, the 24-bit tick width constant and default timing constants.
REQ-032 Sub-module echo_sync (parameterized-width 2-flop synchronizer) SHALL be instantiated once for the echo bus.
REQ-033 Round-robin selection SHALL be combinational from mask and last index; one timer counter SHALL be shared by TRIG, WAIT_RISE/MEASURE timeout and GAP.

Verification (TRIG_CYCLES=4, TIMEOUT_CYCLES=100, GAP_CYCLES=10)
REQ-034 mask=4'b1111, enable=1, each echo high 20 cycles 5 cycles after trigger -> triggers fire order 0,1,2,3,0, each 4 cycles wide; results ids 0..3 with ticks=20, timeout=0.
REQ-035 mask=4'b0100, echo[2] never rises -> trigger[2] repeats; each result id=2, timeout=1, ticks=0, 100 cycles after trigger falls.
REQ-036 mask=4'b0001, echo[0] high 150 cycles -> result timeout=1, ticks = high cycles counted before the 100-cycle limit.
REQ-037 enable dropped during MEASURE of sensor 1 -> sensor 1 result delivered, then GAP, then IDLE, busy=0.
REQ-038 reset_l pulsed low during TRIG of sensor 2 -> trigger=0 same cycle, no result_valid; after release first ping is sensor 0.
REQ-039 echo[3] toggling while sensor 1 measured, mask=4'b1010 -> sensor 1 result unaffected; next trigger is sensor 3.
